// File: rtl/mux8_rr_sched_if.sv
// rtl/mux8_rr_sched_if.sv - output word handshake between the scheduler and its consumer
interface mux8_rr_sched_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/mux8_rr_sched.sv
// rtl/mux8_rr_sched.sv - round-robin scheduler driving an 8:1 mux select and registering the chosen word
module mux8_rr_sched #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req,
  input  logic [WIDTH-1:0]  mux_o,
  output logic [2:0]        sel,
  output logic [7:0]        grant,
  mux8_rr_sched_if.master   out_if
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       grant_q, grant_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             found;
  logic [2:0]       pick;
  logic [2:0]       idx;

  // First set request bit at or after ptr, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grant_d     = 8'd0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          sel_d   = pick;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        out_data_d  = mux_o;
        out_valid_d = 1'b1;
        grant_d     = 8'd1 << sel_q;
        ptr_d       = sel_q + 3'd1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && out_if.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      sel_q       <= 3'd0;
      grant_q     <= 8'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel              = sel_q;
  assign grant            = grant_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb/tb_mux8_rr_sched.sv - directed self-checking bench for mux8_rr_sched
module tb_mux8_rr_sched;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [15:0] mux_o;
  logic [2:0]  sel;
  logic [7:0]  grant;
  logic [15:0] mux_in [8];

  int n_tests;
  int n_fail;

  mux8_rr_sched_if #(.WIDTH(16)) out_if ();

  mux8_rr_sched #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .mux_o  (mux_o),
    .sel    (sel),
    .grant  (grant),
    .out_if (out_if.master)
  );

  // Mux stand-in: input k carries k+1.
  assign mux_o = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] src;
  logic [7:0] onehot;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 8; i++) mux_in[i] = 16'(i + 1);
    rst = 1'b1;
    req = 8'hFF;
    out_if.out_ready = 1'b0;

    // reset with all requests pending
    step();
    step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_data", 32'(out_if.out_data), 32'd0);
    chk("rst_valid", 32'(out_if.out_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("first_sel", 32'(sel), 32'd0);
    chk("first_valid_pre", 32'(out_if.out_valid), 32'd0);
    step();
    chk("first_grant", 32'(grant), 32'h01);
    chk("first_data", 32'(out_if.out_data), 32'd1);
    req = 8'h00;
    out_if.out_ready = 1'b1;
    step();
    chk("first_hs_valid", 32'(out_if.out_valid), 32'd0);
    chk("first_hs_grant", 32'(grant), 32'd0);

    // single request on source 3, ready already high
    req = 8'h08;
    step();
    chk("single_sel", 32'(sel), 32'd3);
    chk("single_grant_pre", 32'(grant), 32'd0);
    step();
    chk("single_data", 32'(out_if.out_data), 32'd4);
    chk("single_valid", 32'(out_if.out_valid), 32'd1);
    chk("single_grant", 32'(grant), 32'h08);
    req = 8'h00;
    step();
    chk("single_hs_valid", 32'(out_if.out_valid), 32'd0);
    chk("single_grant_off", 32'(grant), 32'd0);
    chk("single_sel_hold", 32'(sel), 32'd3);

    // full round-robin from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'hFF;
    for (int j = 0; j < 9; j++) begin
      src    = 3'(j % 8);
      onehot = 8'd1 << src;
      step();
      chk("rr_sel", 32'(sel), 32'(src));
      chk("rr_grant_pre", 32'(grant), 32'd0);
      step();
      chk("rr_grant", 32'(grant), 32'(onehot));
      chk("rr_data", 32'(out_if.out_data), 32'(src) + 32'd1);
      step();
      chk("rr_hs_valid", 32'(out_if.out_valid), 32'd0);
    end
    req = 8'h00;

    // backpressure on source 5
    out_if.out_ready = 1'b0;
    req = 8'h20;
    step();
    chk("bp_sel", 32'(sel), 32'd5);
    step();
    chk("bp_grant", 32'(grant), 32'h20);
    chk("bp_data", 32'(out_if.out_data), 32'd6);
    req = 8'h00;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("bp_hold_valid", 32'(out_if.out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_if.out_data), 32'd6);
      chk("bp_hold_sel", 32'(sel), 32'd5);
      chk("bp_hold_grant", 32'(grant), 32'd0);
    end
    out_if.out_ready = 1'b1;
    step();
    chk("bp_hs_valid", 32'(out_if.out_valid), 32'd0);
    step();
    chk("bp_idle_valid", 32'(out_if.out_valid), 32'd0);
    chk("bp_idle_grant", 32'(grant), 32'd0);

    // wrap-around: grant 6 leaves ptr at 7, then 0 beats 6
    req = 8'h40;
    step();
    chk("wrap_pre_sel", 32'(sel), 32'd6);
    step();
    chk("wrap_pre_grant", 32'(grant), 32'h40);
    req = 8'h00;
    step();
    req = 8'h41;
    step();
    chk("wrap_sel", 32'(sel), 32'd0);
    step();
    chk("wrap_grant", 32'(grant), 32'h01);
    chk("wrap_data", 32'(out_if.out_data), 32'd1);
    req = 8'h00;
    step();
    chk("wrap_hs_valid", 32'(out_if.out_valid), 32'd0);

    // reset while holding source 2's word
    out_if.out_ready = 1'b0;
    req = 8'h04;
    step();
    chk("mid_sel", 32'(sel), 32'd2);
    step();
    chk("mid_grant", 32'(grant), 32'h04);
    chk("mid_data", 32'(out_if.out_data), 32'd3);
    step();
    chk("mid_hold_valid", 32'(out_if.out_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_if.out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_if.out_data), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    rst = 1'b0;
    req = 8'h84;
    out_if.out_ready = 1'b1;
    step();
    chk("post_rst_sel", 32'(sel), 32'd2);
    step();
    chk("post_rst_grant", 32'(grant), 32'h04);
    chk("post_rst_data", 32'(out_if.out_data), 32'd3);
    req = 8'h80;
    step();
    step();
    chk("post_rst_sel7", 32'(sel), 32'd7);
    step();
    chk("post_rst_grant7", 32'(grant), 32'h80);
    chk("post_rst_data7", 32'(out_if.out_data), 32'd8);
    req = 8'h00;
    step();
    chk("post_rst_hs", 32'(out_if.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
